// File: rtl/fht_input_loader.sv
// rtl/fht_input_loader.sv - natural-order sample loader writing bit-reversed frames into four FHT RAM banks
// Owns the bank write ports while a frame fills, then hands them to the FHT and waits for it to finish.
module fht_input_loader #(
  parameter int D_BIT = 16,
  parameter int A_BIT = 8,
  parameter int N_BIT = 10
) (
  input  logic             iCLK,
  input  logic             iRESET,
  input  logic [D_BIT-1:0] iDATA,
  input  logic             iVALID,
  input  logic             iFIRST,
  output logic             oREADY,
  output logic [D_BIT-1:0] oDATA_WR,
  output logic [A_BIT-1:0] oADDR_WR,
  output logic [3:0]       oWE,
  output logic             oSOURCE_LOAD,
  output logic             oSTART,
  input  logic             iFHT_RDY,
  output logic             oFRAME_DONE,
  output logic             oSYNC_ERR,
  output logic             oSTART_ERR
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    FLUSH = 3'd2,
    START = 3'd3,
    ACK   = 3'd4,
    RUN   = 3'd5
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [N_BIT-1:0] n;
  logic [N_BIT-1:0] idx;
  logic [N_BIT-1:0] rev;
  logic [1:0]       ack_cnt;
  logic             accept;
  logic             restart;

  assign accept = iVALID & oREADY;

  // iFIRST forces the accepted sample to index 0, realigning the frame
  assign idx = iFIRST ? '0 : n;

  always_comb begin
    rev = '0;
    for (int i = 0; i < N_BIT; i++) begin
      rev[i] = idx[N_BIT-1-i];
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (iFHT_RDY) next_state = LOAD;
      LOAD:    if (accept && (&idx)) next_state = FLUSH;
      FLUSH:   next_state = START;
      START:   next_state = ACK;
      ACK: begin
        if (!iFHT_RDY) begin
          next_state = RUN;
        end else if (ack_cnt == 2'd3) begin
          next_state = LOAD;
        end
      end
      RUN:     if (iFHT_RDY) next_state = LOAD;
      default: next_state = IDLE;
    endcase
  end

  assign restart = ((state == ACK) || (state == RUN)) && (next_state == LOAD);

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      state        <= IDLE;
      n            <= '0;
      ack_cnt      <= '0;
      oREADY       <= 1'b0;
      oWE          <= '0;
      oADDR_WR     <= '0;
      oDATA_WR     <= '0;
      oSOURCE_LOAD <= 1'b0;
      oSTART       <= 1'b0;
      oFRAME_DONE  <= 1'b0;
      oSYNC_ERR    <= 1'b0;
      oSTART_ERR   <= 1'b0;
    end else begin
      state        <= next_state;
      oREADY       <= (next_state == LOAD);
      oSOURCE_LOAD <= (next_state == LOAD) || (next_state == FLUSH);
      oSTART       <= (next_state == START);
      oFRAME_DONE  <= (state == RUN) && (next_state == LOAD);
      oSTART_ERR   <= (state == ACK) && (next_state == LOAD);
      oSYNC_ERR    <= accept && iFIRST && (n != '0);
      ack_cnt      <= (state == ACK) ? ack_cnt + 2'd1 : 2'd0;
      oWE          <= '0;
      if (accept) begin
        oWE      <= 4'b0001 << rev[1:0];
        oADDR_WR <= rev[N_BIT-1:2];
        oDATA_WR <= iDATA;
        n        <= idx + 1'b1;
      end
      if (restart) begin
        n <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fht_input_loader.sv
// tb/tb_fht_input_loader.sv - randomized and directed bench for fht_input_loader against a behavioural model
module tb_fht_input_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] din = '0;
  logic        vld = 1'b0;
  logic        first = 1'b0;
  logic        rdy = 1'b0;
  logic        oREADY;
  logic [15:0] oDATA_WR;
  logic [7:0]  oADDR_WR;
  logic [3:0]  oWE;
  logic        oSOURCE_LOAD;
  logic        oSTART;
  logic        oFRAME_DONE;
  logic        oSYNC_ERR;
  logic        oSTART_ERR;

  fht_input_loader #(.D_BIT(16), .A_BIT(8), .N_BIT(10)) dut (
    .iCLK(clk), .iRESET(rst), .iDATA(din), .iVALID(vld), .iFIRST(first),
    .oREADY(oREADY), .oDATA_WR(oDATA_WR), .oADDR_WR(oADDR_WR), .oWE(oWE),
    .oSOURCE_LOAD(oSOURCE_LOAD), .oSTART(oSTART), .iFHT_RDY(rdy),
    .oFRAME_DONE(oFRAME_DONE), .oSYNC_ERR(oSYNC_ERR), .oSTART_ERR(oSTART_ERR)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: phases follow the described loader life cycle
  typedef enum int {P_IDLE, P_FILL, P_DRAIN, P_KICK, P_WAIT_ACK, P_BUSY} ph_t;
  ph_t ph = P_IDLE;
  int  m_n = 0;
  int  ack_wait = 0;
  int  e_ready = 0, e_we = 0, e_addr = 0, e_data = 0, e_src = 0;
  int  e_start = 0, e_done = 0, e_sync = 0, e_serr = 0;

  function automatic int bitrev10(input int v);
    int r = 0;
    int x = v;
    for (int b = 0; b < 10; b++) begin
      r = r * 2 + (x % 2);
      x = x / 2;
    end
    return r;
  endfunction

  always @(posedge clk) begin
    int  idx, r;
    bit  acc;
    acc = vld && (e_ready != 0);
    idx = first ? 0 : m_n;
    e_we = 0; e_start = 0; e_done = 0; e_sync = 0; e_serr = 0;
    if (rst) begin
      ph = P_IDLE; m_n = 0; e_addr = 0; e_data = 0;
    end else begin
      if (acc) begin
        if (first && m_n != 0) e_sync = 1;
        r = bitrev10(idx);
        e_we = 1 << (r % 4);
        e_addr = r / 4;
        e_data = int'(din);
        m_n = (idx + 1) % 1024;
      end
      case (ph)
        P_IDLE:  if (rdy) ph = P_FILL;
        P_FILL:  if (acc && idx == 1023) ph = P_DRAIN;
        P_DRAIN: ph = P_KICK;
        P_KICK:  begin ph = P_WAIT_ACK; ack_wait = 0; end
        P_WAIT_ACK: begin
          if (!rdy) ph = P_BUSY;
          else begin
            ack_wait++;
            if (ack_wait == 4) begin ph = P_FILL; e_serr = 1; m_n = 0; end
          end
        end
        P_BUSY: if (rdy) begin ph = P_FILL; e_done = 1; m_n = 0; end
        default: ph = P_IDLE;
      endcase
    end
    e_ready = (ph == P_FILL) ? 1 : 0;
    e_src   = (ph == P_FILL || ph == P_DRAIN) ? 1 : 0;
    e_start = (ph == P_KICK) ? 1 : 0;
  end

  int cnt_we = 0, cnt_start = 0, cnt_done = 0, cnt_sync = 0, cnt_serr = 0;
  int bank_of [1024];
  int addr_of [1024];
  bit capture = 0;

  always @(negedge clk) begin
    chk("ready", oREADY, e_ready);
    chk("we", oWE, e_we);
    chk("addr", oADDR_WR, e_addr);
    chk("data", oDATA_WR, e_data);
    chk("source_load", oSOURCE_LOAD, e_src);
    chk("start", oSTART, e_start);
    chk("frame_done", oFRAME_DONE, e_done);
    chk("sync_err", oSYNC_ERR, e_sync);
    chk("start_err", oSTART_ERR, e_serr);
    if (oWE != 0) begin
      cnt_we++;
      if (capture) begin
        for (int b = 0; b < 4; b++) if (oWE[b]) bank_of[oDATA_WR[9:0]] = b;
        addr_of[oDATA_WR[9:0]] = oADDR_WR;
      end
    end
    cnt_start += oSTART;
    cnt_done  += oFRAME_DONE;
    cnt_sync  += oSYNC_ERR;
    cnt_serr  += oSTART_ERR;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d, input logic f);
    bit acc = 0;
    din = d; first = f; vld = 1'b1;
    for (int k = 0; k < 50 && !acc; k++) begin
      acc = oREADY;
      tick();
    end
    vld = 1'b0; first = 1'b0;
    if (!acc) begin
      miscompares++;
      $display("FAIL send_timeout: sample %0d not accepted within 50 cycles", d);
    end
  endtask

  initial begin
    int s0, d0, w0;
    repeat (3) tick();
    chk("reset_ready", oREADY, 0);
    chk("reset_we", oWE, 0);
    rst = 1'b0; rdy = 1'b1;
    tick();
    chk("load_ready", oREADY, 1);
    chk("load_src", oSOURCE_LOAD, 1);

    // Frame 1: data = n, FHT drops ready for 5000 cycles
    cnt_we = 0; capture = 1;
    for (int i = 0; i < 1024; i++) send(16'(i), i == 0);
    rdy = 1'b0;
    repeat (3) tick();
    capture = 0;
    chk("frame1_writes", cnt_we, 1024);
    chk("frame1_starts", cnt_start, 1);
    chk("n1_bank", bank_of[1], 0);
    chk("n1_addr", addr_of[1], 128);
    chk("n3_bank", bank_of[3], 0);
    chk("n3_addr", addr_of[3], 192);
    chk("n512_bank", bank_of[512], 1);
    chk("n512_addr", addr_of[512], 0);
    repeat (5000) tick();
    rdy = 1'b1;
    repeat (2) tick();
    chk("frame1_done", cnt_done, 1);
    chk("frame1_ready_again", oREADY, 1);

    // Frame 2: FHT never acknowledges start
    for (int i = 0; i < 1024; i++) send(16'($urandom), 1'b0);
    repeat (8) tick();
    chk("start_err_count", cnt_serr, 1);
    chk("no_done_on_start_err", cnt_done, 1);
    chk("ready_after_start_err", oREADY, 1);

    // Realignment mid-frame
    for (int i = 0; i < 300; i++) send(16'($urandom), 1'b0);
    send(16'hABCD, 1'b1);
    chk("sync_pulse", oSYNC_ERR, 1);
    chk("sync_we", oWE, 1);
    chk("sync_addr", oADDR_WR, 0);
    chk("sync_data", oDATA_WR, 16'hABCD);
    s0 = cnt_start;
    for (int i = 0; i < 1023; i++) send(16'($urandom), 1'b0);
    rdy = 1'b0;
    repeat (4) tick();
    chk("sync_frame_start", cnt_start, s0 + 1);
    chk("sync_count", cnt_sync, 1);
    rdy = 1'b1;
    repeat (2) tick();

    // Reset mid-frame discards the partial frame
    for (int i = 0; i < 700; i++) send(16'($urandom), 1'b0);
    vld = 1'b1; rst = 1'b1;
    tick();
    chk("rst_ready", oREADY, 0);
    chk("rst_we", oWE, 0);
    chk("rst_addr", oADDR_WR, 0);
    chk("rst_data", oDATA_WR, 0);
    chk("rst_src", oSOURCE_LOAD, 0);
    rst = 1'b0; vld = 1'b0;
    tick();
    s0 = cnt_start; d0 = cnt_done; w0 = cnt_we;
    for (int i = 0; i < 1023; i++) send(16'($urandom), 1'b0);
    repeat (4) tick();
    chk("no_start_short_frame", cnt_start, s0);
    send(16'h5A5A, 1'b0);
    rdy = 1'b0;
    repeat (4) tick();
    chk("start_after_full_frame", cnt_start, s0 + 1);
    chk("writes_after_reset", cnt_we - w0, 1024);
    rdy = 1'b1;
    repeat (2) tick();
    chk("done_after_reset_frame", cnt_done, d0 + 1);

    // Randomized traffic with a wandering FHT ready flag and rare resets
    for (int c = 0; c < 20000; c++) begin
      vld   = ($urandom % 4) != 0;
      din   = 16'($urandom);
      first = ($urandom % 3000) == 0;
      if ($urandom % 40 == 0) rdy = ~rdy;
      rst   = ($urandom % 5000) == 0;
      tick();
    end
    rst = 1'b0; vld = 1'b0;
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
